// File: rtl/mcu_spi_pkg.sv
// Shared types and widths for the MCU SPI responder: FSM state encoding and frame field positions.
package mcu_spi_pkg;

   localparam int MCU_SPI_ADDR_BITS = 7;
   localparam int MCU_SPI_RW_BIT    = 7;
   localparam int MCU_SPI_BYTE_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WRITE,
      ST_READ
   } mcu_spi_state_e;

endpackage

// File: rtl/mcu_spi_responder_if.sv
// Register-file access bus between the SPI responder (master) and the FPGA register file (slave).
interface mcu_spi_responder_if;
   import mcu_spi_pkg::*;

   logic [MCU_SPI_ADDR_BITS-1:0] reg_addr;
   logic                         reg_wr_en;
   logic [MCU_SPI_BYTE_BITS-1:0] reg_wr_data;
   logic                         reg_rd_en;
   logic [MCU_SPI_BYTE_BITS-1:0] reg_rd_data;

   modport master (
      output reg_addr,
      output reg_wr_en,
      output reg_wr_data,
      output reg_rd_en,
      input  reg_rd_data
   );

   modport slave (
      input  reg_addr,
      input  reg_wr_en,
      input  reg_wr_data,
      input  reg_rd_en,
      output reg_rd_data
   );

endinterface

// File: rtl/mcu_spi_pin_sync.sv
// Multi-stage synchronizer for one asynchronous pin, followed by a registered level and rise/fall pulses.
module mcu_spi_pin_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_p0;

   // Synchronizer chain -> edge-detect stage (level, rise and fall stay cycle-aligned)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_p0 <= {STAGES{RST_VAL}};
         level   <= RST_VAL;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         sync_p0 <= {sync_p0[STAGES-2:0], pin};
         level   <= sync_p0[STAGES-1];
         rise    <= sync_p0[STAGES-1] & ~level;
         fall    <= ~sync_p0[STAGES-1] & level;
      end
   end

endmodule

// File: rtl/mcu_spi_responder.sv
// SPI mode-0 responder: oversampled frame decode into register read/write strobes, read data on MISO.
// Define MCU_SPI_AUTOINC_EN to auto-increment the register address after each data byte.
module mcu_spi_responder
   import mcu_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk_50mhz,
   input  logic                       rst_n,
   input  logic                       spi_sck,
   input  logic                       spi_cs_n,
   input  logic                       spi_mosi,
   output logic                       spi_miso,
   output logic                       frame_active,
   mcu_spi_responder_if.master        reg_bus
);

   logic sck_level_unused, sck_rise, sck_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   mcu_spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk   (clk_50mhz),
      .rst_n (rst_n),
      .pin   (spi_sck),
      .level (sck_level_unused),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   // cs_rise is deselect, cs_fall is select (pin is active low)
   mcu_spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk_50mhz),
      .rst_n (rst_n),
      .pin   (spi_cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   mcu_spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
      .clk   (clk_50mhz),
      .rst_n (rst_n),
      .pin   (spi_mosi),
      .level (mosi_level),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   mcu_spi_state_e               state;
   logic [2:0]                   bit_cnt;
   logic [MCU_SPI_BYTE_BITS-1:0] shift_r;
   logic [MCU_SPI_BYTE_BITS-1:0] rx_byte;
   logic [MCU_SPI_BYTE_BITS-1:0] tx_r;
   logic [MCU_SPI_ADDR_BITS-1:0] addr_r;
   logic                         rd_vld_p1;
   logic [SYNC_STAGES+1:0]       flush_r;
   logic                         armed;

   assign rx_byte  = {shift_r[MCU_SPI_BYTE_BITS-2:0], mosi_level};
   assign spi_miso = (state == ST_READ) & tx_r[MCU_SPI_BYTE_BITS-1];

   function automatic logic [MCU_SPI_ADDR_BITS-1:0] next_addr(input logic [MCU_SPI_ADDR_BITS-1:0] a);
`ifdef MCU_SPI_AUTOINC_EN
      return a + 1'b1;
`else
      return a;
`endif
   endfunction

   // A CS fall is only honoured once CS has been seen high after the synchronizers flush,
   // so a CS held low through reset cannot start a frame mid-transfer.
   always_ff @(posedge clk_50mhz) begin
      reg_bus.reg_wr_en <= 1'b0;
      reg_bus.reg_rd_en <= 1'b0;
      if (!rst_n) begin
         state               <= ST_IDLE;
         bit_cnt             <= '0;
         shift_r             <= '0;
         tx_r                <= '0;
         addr_r              <= '0;
         rd_vld_p1           <= 1'b0;
         flush_r             <= '0;
         armed               <= 1'b0;
         frame_active        <= 1'b0;
         reg_bus.reg_addr    <= '0;
         reg_bus.reg_wr_data <= '0;
      end else begin
         flush_r   <= {flush_r[SYNC_STAGES:0], 1'b1};
         if (flush_r[SYNC_STAGES+1] && cs_level)
            armed <= 1'b1;

         // Read strobe -> register file returns data one cycle later -> TX load
         rd_vld_p1 <= reg_bus.reg_rd_en;
         if (rd_vld_p1)
            tx_r <= reg_bus.reg_rd_data;
         else if (state == ST_READ && sck_fall && bit_cnt != 3'd0)
            tx_r <= {tx_r[MCU_SPI_BYTE_BITS-2:0], 1'b0};

         if (state == ST_IDLE) begin
            if (cs_fall && armed) begin
               state        <= ST_ADDR;
               bit_cnt      <= '0;
               frame_active <= 1'b1;
            end
         end else begin
            if (sck_rise) begin
               bit_cnt <= bit_cnt + 3'd1;
               shift_r <= rx_byte;
               if (bit_cnt == 3'd7) begin
                  if (state == ST_ADDR) begin
                     addr_r <= rx_byte[MCU_SPI_ADDR_BITS-1:0];
                     if (rx_byte[MCU_SPI_RW_BIT]) begin
                        reg_bus.reg_rd_en <= 1'b1;
                        reg_bus.reg_addr  <= rx_byte[MCU_SPI_ADDR_BITS-1:0];
                        state             <= ST_READ;
                     end else begin
                        state <= ST_WRITE;
                     end
                  end else if (state == ST_WRITE) begin
                     reg_bus.reg_wr_en   <= 1'b1;
                     reg_bus.reg_addr    <= addr_r;
                     reg_bus.reg_wr_data <= rx_byte;
                     addr_r              <= next_addr(addr_r);
                  end else begin
                     // Prefetch the next byte even if the MCU is about to deselect
                     reg_bus.reg_rd_en <= 1'b1;
                     reg_bus.reg_addr  <= next_addr(addr_r);
                     addr_r            <= next_addr(addr_r);
                  end
               end
            end
            // Deselect wins over the state change above but not over the strobe
            if (cs_rise) begin
               state        <= ST_IDLE;
               frame_active <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mcu_spi_responder.sv
// Directed bench for mcu_spi_responder: write, read, wrap, abort, reset-with-CS-low and deselect-on-last-bit frames.
`timescale 1ns/1ps
module tb_mcu_spi_responder;

   logic clk = 1'b0;
   logic rst_n;
   logic sck, cs_n, mosi;
   logic miso, frame_active;

   mcu_spi_responder_if rbus();

   mcu_spi_responder dut (
      .clk_50mhz    (clk),
      .rst_n        (rst_n),
      .spi_sck      (sck),
      .spi_cs_n     (cs_n),
      .spi_mosi     (mosi),
      .spi_miso     (miso),
      .frame_active (frame_active),
      .reg_bus      (rbus)
   );

   always #5 clk = ~clk;

   // Register file model: read data is addr+0x40 for exactly the cycle after the strobe
   always @(posedge clk)
      rbus.reg_rd_data <= rbus.reg_rd_en ? ({1'b0, rbus.reg_addr} + 8'h40) : 8'hEE;

   logic [14:0] wr_q[$];
   logic [6:0]  rd_q[$];

   always @(negedge clk) begin
      if (rbus.reg_wr_en) wr_q.push_back({rbus.reg_addr, rbus.reg_wr_data});
      if (rbus.reg_rd_en) rd_q.push_back(rbus.reg_addr);
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] nxt(input logic [6:0] a);
`ifdef MCU_SPI_AUTOINC_EN
      return a + 7'd1;
`else
      return a;
`endif
   endfunction

   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = b[7-i];
         #50;
         sck = 1'b1;
         rx  = {rx[6:0], miso};
         #50;
         sck = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_miso"},   32'(miso), 32'h0);
      chk({tag, "_addr"},   32'(rbus.reg_addr), 32'h0);
      chk({tag, "_wr_en"},  32'(rbus.reg_wr_en), 32'h0);
      chk({tag, "_wr_data"},32'(rbus.reg_wr_data), 32'h0);
      chk({tag, "_rd_en"},  32'(rbus.reg_rd_en), 32'h0);
      chk({tag, "_active"}, 32'(frame_active), 32'h0);
   endtask

   initial begin
      logic [7:0] rx;
      logic [6:0] a;
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sck   = 1'b0;
      mosi  = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      #200;

      // Write frame 0x05, 0xA5, 0x3C
      wr_q.delete(); rd_q.delete();
      cs_n = 1'b0; #100;
      chk("wr_frame_active", 32'(frame_active), 32'h1);
      spi_bits(8'h05, 8, rx);
      spi_bits(8'hA5, 8, rx);
      spi_bits(8'h3C, 8, rx);
      #50; cs_n = 1'b1; #200;
      chk("wr_frame_idle", 32'(frame_active), 32'h0);
      chk("wr_count", 32'(wr_q.size()), 32'd2);
      chk("wr_0", 32'(wr_q[0]), 32'({7'h05, 8'hA5}));
      chk("wr_1", 32'(wr_q[1]), 32'({nxt(7'h05), 8'h3C}));
      chk("wr_no_rd", 32'(rd_q.size()), 32'd0);

      // Read frame 0x90, 0x00, 0x00
      wr_q.delete(); rd_q.delete();
      cs_n = 1'b0; #100;
      spi_bits(8'h90, 8, rx);
      chk("rd_addr_miso", 32'(rx), 32'h00);
      spi_bits(8'h00, 8, rx);
      chk("rd_byte0", 32'(rx), 32'h50);
      spi_bits(8'h00, 8, rx);
      a = nxt(7'h10);
      chk("rd_byte1", 32'(rx), 32'({1'b0, a}) + 32'h40);
      #50; cs_n = 1'b1; #200;
      chk("rd_miso_idle", 32'(miso), 32'h0);
      chk("rd_count", 32'(rd_q.size()), 32'd3);
      chk("rd_0", 32'(rd_q[0]), 32'h10);
      chk("rd_1", 32'(rd_q[1]), 32'(nxt(7'h10)));
      chk("rd_2", 32'(rd_q[2]), 32'(nxt(nxt(7'h10))));
      chk("rd_no_wr", 32'(wr_q.size()), 32'd0);

      // Address wrap 0x7F -> 0x00
      wr_q.delete(); rd_q.delete();
      cs_n = 1'b0; #100;
      spi_bits(8'h7F, 8, rx);
      spi_bits(8'h11, 8, rx);
      spi_bits(8'h22, 8, rx);
      #50; cs_n = 1'b1; #200;
      chk("wrap_count", 32'(wr_q.size()), 32'd2);
      chk("wrap_0", 32'(wr_q[0]), 32'({7'h7F, 8'h11}));
      chk("wrap_1", 32'(wr_q[1]), 32'({nxt(7'h7F), 8'h22}));

      // Abort after 5 data bits, then a clean frame
      wr_q.delete(); rd_q.delete();
      cs_n = 1'b0; #100;
      spi_bits(8'h05, 8, rx);
      spi_bits(8'hFF, 5, rx);
      #50; cs_n = 1'b1; #200;
      chk("abort_no_wr", 32'(wr_q.size()), 32'd0);
      cs_n = 1'b0; #100;
      spi_bits(8'h06, 8, rx);
      spi_bits(8'h77, 8, rx);
      #50; cs_n = 1'b1; #200;
      chk("post_abort_count", 32'(wr_q.size()), 32'd1);
      chk("post_abort_wr", 32'(wr_q[0]), 32'({7'h06, 8'h77}));

      // Reset mid-frame with CS held low through release
      wr_q.delete(); rd_q.delete();
      cs_n = 1'b0; #100;
      spi_bits(8'h05, 8, rx);
      spi_bits(8'hFF, 3, rx);
      rst_n = 1'b0; #50;
      chk_reset_outputs("midrst");
      rst_n = 1'b1; #200;
      spi_bits(8'h05, 8, rx);
      spi_bits(8'h11, 8, rx);
      #200;
      chk("midrst_inactive", 32'(frame_active), 32'h0);
      chk("midrst_no_wr", 32'(wr_q.size()), 32'd0);
      chk("midrst_no_rd", 32'(rd_q.size()), 32'd0);
      cs_n = 1'b1; #200;
      cs_n = 1'b0; #100;
      spi_bits(8'h08, 8, rx);
      spi_bits(8'h99, 8, rx);
      #50; cs_n = 1'b1; #200;
      chk("midrst_wr_count", 32'(wr_q.size()), 32'd1);
      chk("midrst_wr", 32'(wr_q[0]), 32'({7'h08, 8'h99}));

      // Multi-byte write: address fixed or incrementing depending on build
      wr_q.delete(); rd_q.delete();
      cs_n = 1'b0; #100;
      spi_bits(8'h05, 8, rx);
      spi_bits(8'h01, 8, rx);
      spi_bits(8'h02, 8, rx);
      spi_bits(8'h03, 8, rx);
      #50; cs_n = 1'b1; #200;
      chk("multi_count", 32'(wr_q.size()), 32'd3);
      chk("multi_0", 32'(wr_q[0]), 32'({7'h05, 8'h01}));
      chk("multi_1", 32'(wr_q[1]), 32'({nxt(7'h05), 8'h02}));
      chk("multi_2", 32'(wr_q[2]), 32'({nxt(nxt(7'h05)), 8'h03}));

      // Deselect on the same edge as the last data bit still commits the byte
      wr_q.delete(); rd_q.delete();
      cs_n = 1'b0; #100;
      spi_bits(8'h20, 8, rx);
      spi_bits(8'h5A, 7, rx);
      mosi = 1'b0; #50;
      sck  = 1'b1;
      cs_n = 1'b1; #50;
      sck  = 1'b0; #200;
      chk("simul_count", 32'(wr_q.size()), 32'd1);
      chk("simul_wr", 32'(wr_q[0]), 32'({7'h20, 8'h5A}));
      chk("simul_idle", 32'(frame_active), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
